apple1_uart_rx: RTL and testbench
=================================

# apple1_uart_rx

Serial receive front end for the Apple-1 host link. It takes the raw `uart_rx` pin from the PC-side UART and deserialises 8N1 frames. Received bytes are buffered in a 4-entry FIFO that the keyboard/PIA path drains, and `uart_cts` provides hardware flow control back to the host. It sits between the board pin and the core's keyboard register, in the same clock domain as the rest of the core.

## Interface
- `CLK_FREQ`, 25000000: core clock frequency in Hz.
- `BAUD`, 115200: line rate. N = CLK_FREQ/BAUD (integer division) clocks per bit. Simulation uses BAUD = 2500000, so N = 10. N < 4 is illegal and must trip an elaboration `$error`.
- `clk25`  in  1  core clock. One clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `uart_rx`  in  1  asynchronous serial line; idles high.
- `rx_ready`  in  1  consumer pops the FIFO head this cycle (only effective while `rx_valid`).
- `err_clr`  in  1  clears `frame_err` and `overrun`.
- `rx_data`  out  8  FIFO head (show-ahead); 0x00 when empty.
- `rx_valid`  out  1  FIFO non-empty.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `overrun`  out  1  sticky: a good byte arrived while the FIFO was full.
- `uart_cts`  out  1  1 = host may send; registered.

## Operation
- **Input synchroniser.** 2-flop synchroniser on `uart_rx` produces `rx_s`; everything downstream uses `rx_s` only. Both flops reset to 1.
- **FSM states:** WAIT_HIGH, IDLE, START, DATA, STOP.
  - Reset enters WAIT_HIGH. WAIT_HIGH moves to IDLE on the first cycle with `rx_s` = 1, so a line held low across reset is never taken as a start bit.
  - IDLE: `rx_s` = 0 moves to START and loads the bit counter. That cycle is T0.
  - START: at T0+H (H = N/2, integer), sample `rx_s`. If 1 it is a glitch: go to IDLE, nothing pushed. If 0, go to DATA.
  - DATA: bit i (i = 0..7, LSB first) is sampled at T0+H+(i+1)·N and shifted in. After bit 7, go to STOP.
  - STOP: sample at T0+H+9·N.
    - Sample = 1: push the byte and go to IDLE in the same cycle, so back-to-back frames are accepted with no idle bit.
    - Sample = 0: set `frame_err`, discard the byte, go to WAIT_HIGH (this also absorbs a break condition).
- **FIFO.** 4 entries, with a 3-bit count 0..4 and 2-bit wrapping read/write pointers.
  - Push while count = 4 and no pop: drop the byte, set `overrun`, FIFO contents unchanged.
  - Push and pop in the same cycle when full: both succeed, count stays 4, no overrun.
  - Push and pop in the same cycle when count = 1: the new byte becomes head, count stays 1.
  - Pop while empty: ignored.
- **Flow control.** `uart_cts` <= (count_next < 3). It drops at the latest one cycle after the 3rd byte is stored, which leaves one slot of slack for a frame already in flight.
- **Sticky errors.** `err_clr` clears both flags. If a new error is raised in the same cycle, the error wins and the flag stays 1.
- **Reset behaviour.**
  - Values in reset: `rx_valid` 0, `rx_data` 0x00, `frame_err` 0, `overrun` 0, `uart_cts` 0; FIFO flushed.
  - `uart_cts` becomes 1 on the first cycle after `rst` deasserts.
  - Reset asserted mid-frame aborts the frame; no partial byte is ever pushed.

## Timing
- Pin to `rx_s`: 2 cycles.
- The push happens on the STOP-sample edge. `rx_valid`/`rx_data` reflect it on the following cycle: T0+H+9·N+1, which is T0+96 for N = 10.
- A pop on cycle t updates `rx_data`/`rx_valid` at t+1.
- One bit period is exactly N cycles, with no accumulated drift. Bit counter and clock counter are both reloaded at T0 only.
- Minimum frame accepted: start + 8 data + stop = 10·N cycles start-to-start.

## Test plan
- **Single byte (N = 10).** Release reset. After 4500 cycles, drive the pin as 0 for 10 cycles (start), data bits LSB first 1,0,1,1,0,0,0,0 (10 cycles each), then high. Required: `rx_data` = 0x0D and `rx_valid` = 1, 96 cycles after `rx_s` falls; `frame_err` = 0.
- **Glitch rejection.** Pulse the pin low for 3 cycles. Required: FSM returns to IDLE, `rx_valid` stays 0. A following valid 0x55 frame is then received correctly.
- **Framing error.** Send 0xA5 with the stop bit low, hold the line low 40 cycles, release, then send 0x3C. Required: `frame_err` = 1, 0xA5 not pushed, 0x3C received. `err_clr` then clears `frame_err` on the next cycle.
- **Flow control / overrun.** Send 0x01..0x05 back-to-back with no pops. Required: `uart_cts` falls 1 cycle after 0x03 is stored. FIFO holds 0x01..0x04. 0x05 sets `overrun`. Pops return 0x01, 0x02, 0x03, 0x04, then `rx_valid` = 0. `uart_cts` returns to 1 once count ≤ 2.
- **Full with simultaneous push/pop.** With the FIFO at 4 entries, assert `rx_ready` exactly on the push cycle of 0x77. Required: `overrun` = 0, count = 4, and 0x77 is the last byte popped.
- **Reset mid-frame and reset with line low.** Assert `rst` during data bit 4 while the line is held low through reset release. Required: no byte pushed, `uart_cts` 0 in reset and 1 one cycle after release, no start detected until the line goes high. The next 0x0D frame is received.

Source files
------------

// File: rtl/apple1_uart_rx.sv
// 8N1 serial receiver for the Apple-1 host link: 2-flop synchroniser, bit-timing FSM,
// 4-entry show-ahead FIFO with registered CTS flow control and sticky error flags.
module apple1_uart_rx #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic       rx_ready,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       uart_cts
);

  localparam int N  = CLK_FREQ / BAUD;
  localparam int H  = N / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (N < 4) begin : g_bad_rate
      $error("apple1_uart_rx: CLK_FREQ/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic          sync1, rx_s;
  logic [1:0]    armed;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;
  logic          start_det, bit_smp, push, ferr_set;

  always_ff @(posedge clk25) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rx_s  <= sync1;
    end
  end

  // The synchroniser holds its reset 1s for two cycles after release; WAIT_HIGH must
  // not trust rx_s until the real pin level has propagated through.
  always_ff @(posedge clk25) begin
    if (rst) armed <= 2'b00;
    else     armed <= {armed[0], 1'b1};
  end

  assign tick = (cnt == '0);

  always_ff @(posedge clk25) begin
    if (rst) state <= WAIT_HIGH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      WAIT_HIGH: if (armed[1] && rx_s) state_nx = IDLE;
      IDLE:      if (!rx_s) state_nx = START;
      START:     if (tick) state_nx = rx_s ? IDLE : DATA;
      DATA:      if (tick && bit_idx == 3'd7) state_nx = STOP;
      STOP:      if (tick) state_nx = rx_s ? IDLE : WAIT_HIGH;
      default:   state_nx = WAIT_HIGH;
    endcase
  end

  always_comb begin
    start_det = (state == IDLE) && !rx_s;
    bit_smp   = (state == DATA) && tick;
    push      = (state == STOP) && tick && rx_s;
    ferr_set  = (state == STOP) && tick && !rx_s;
  end

  // Timing counter is loaded only at the start edge and then reloads with N-1 each bit,
  // so every sample sits exactly H + k*N cycles after the start edge.
  always_ff @(posedge clk25) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      if (start_det) begin
        cnt     <= CW'(H - 1);
        bit_idx <= 3'd0;
      end else if (state inside {START, DATA, STOP}) begin
        cnt <= tick ? CW'(N - 1) : cnt - 1'b1;
      end
      if (bit_smp) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  logic [7:0] mem [4];
  logic [1:0] wp, rp;
  logic [2:0] count, count_nx;
  logic       pop, full, push_acc, ovr_set;

  assign pop      = rx_ready && (count != 3'd0);
  assign full     = (count == 3'd4);
  assign push_acc = push && (!full || pop);
  assign ovr_set  = push && full && !pop;
  assign count_nx = count + {2'b00, push_acc} - {2'b00, pop};

  always_ff @(posedge clk25) begin
    if (push_acc) mem[wp] <= shreg;
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      wp       <= 2'd0;
      rp       <= 2'd0;
      count    <= 3'd0;
      uart_cts <= 1'b0;
    end else begin
      if (push_acc) wp <= wp + 2'd1;
      if (pop)      rp <= rp + 2'd1;
      count    <= count_nx;
      uart_cts <= (count_nx < 3'd3);
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set | (frame_err & ~err_clr);
      overrun   <= ovr_set  | (overrun & ~err_clr);
    end
  end

  assign rx_valid = (count != 3'd0);
  assign rx_data  = rx_valid ? mem[rp] : 8'h00;

endmodule

// File: tb/tb_apple1_uart_rx.sv
// Bench for apple1_uart_rx: frame-level reference model (byte queue + flags) checked
// every cycle, plus directed literal checks for each scenario.
module tb_apple1_uart_rx;
  localparam int CLK_FREQ = 25000000;
  localparam int BAUD     = 2500000;
  localparam int N        = CLK_FREQ / BAUD;
  // Pin-low edge to push edge: 2 sync cycles to the start edge, then H + 9 bit periods.
  localparam int LAT      = 2 + N / 2 + 9 * N;

  logic       clk25 = 1'b0;
  logic       rst, uart_rx, rx_ready, err_clr;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, uart_cts;

  apple1_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk25(clk25), .rst(rst), .uart_rx(uart_rx), .rx_ready(rx_ready), .err_clr(err_clr),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .overrun(overrun),
    .uart_cts(uart_cts)
  );

  always #5 clk25 = ~clk25;

  typedef struct {int c; bit ok; logic [7:0] d;} ev_t;

  int         total = 0, bad = 0, cyc = 0;
  bit         chk_en = 0;
  logic [7:0] q[$];
  ev_t        evq[$];
  bit         m_ferr = 0, m_ovr = 0, m_cts = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one frame-complete event per sent frame, applied on its edge.
  initial forever begin
    bit   p, fs, os, psh;
    int   sz;
    ev_t  e;
    @(posedge clk25);
    cyc++;
    p  = rx_ready && (q.size() > 0);
    sz = q.size();
    if (rst) begin
      q.delete(); evq.delete();
      m_ferr = 0; m_ovr = 0; m_cts = 0;
    end else begin
      fs = 0; os = 0; psh = 0;
      if (evq.size() > 0 && evq[0].c == cyc) begin
        e = evq.pop_front();
        if (e.ok) psh = 1; else fs = 1;
      end
      if (p) void'(q.pop_front());
      if (psh) begin
        if (sz == 4 && !p) os = 1;
        else q.push_back(e.d);
      end
      m_ferr = fs | (m_ferr & !err_clr);
      m_ovr  = os | (m_ovr & !err_clr);
      m_cts  = (q.size() < 3);
    end
  end

  initial forever begin
    @(negedge clk25);
    if (chk_en) begin
      chk("cyc_rx_valid",  rx_valid,  q.size() > 0);
      chk("cyc_rx_data",   rx_data,   (q.size() > 0) ? q[0] : 8'h00);
      chk("cyc_frame_err", frame_err, m_ferr);
      chk("cyc_overrun",   overrun,   m_ovr);
      chk("cyc_uart_cts",  uart_cts,  m_cts);
    end
  end

  task automatic tick;
    @(posedge clk25); #2;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin @(posedge clk25); #1; end
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stp);
    ev_t e;
    e.c = cyc + 1 + LAT; e.ok = stp; e.d = b;
    evq.push_back(e);
    uart_rx = 1'b0; repeat (N) tick;
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; repeat (N) tick; end
    uart_rx = stp; repeat (N) tick;
  endtask

  task automatic pop_chk(input logic [7:0] exp);
    chk("pop_valid", rx_valid, 1);
    chk("pop_data", rx_data, exp);
    rx_ready = 1'b1; tick; rx_ready = 1'b0;
  endtask

  initial begin
    int e;
    logic [7:0] b;
    rst = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    repeat (3) tick;
    chk_en = 1;
    chk("rst_cts", uart_cts, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 8'h00);
    rst = 1'b0; tick;
    chk("cts_after_rst", uart_cts, 1);

    // single byte 0x0D with exact push timing
    repeat (4500) tick;
    e = cyc + 1 + LAT;
    fork
      send(8'h0D, 1'b1);
      begin
        wait_cyc(e - 1); chk("t1_valid_early", rx_valid, 0);
        wait_cyc(e);     chk("t1_valid", rx_valid, 1);
        chk("t1_data", rx_data, 8'h0D); chk("t1_ferr", frame_err, 0);
      end
    join
    pop_chk(8'h0D);

    // glitch rejection then 0x55
    uart_rx = 1'b0; repeat (3) tick; uart_rx = 1'b1;
    repeat (30) tick;
    chk("glitch_valid", rx_valid, 0);
    send(8'h55, 1'b1); repeat (5) tick;
    pop_chk(8'h55);

    // framing error, line low, then 0x3C
    send(8'hA5, 1'b0); repeat (40) tick; uart_rx = 1'b1;
    repeat (20) tick;
    send(8'h3C, 1'b1); repeat (5) tick;
    chk("fe_flag", frame_err, 1);
    chk("fe_data", rx_data, 8'h3C);
    err_clr = 1'b1; tick; err_clr = 1'b0;
    chk("fe_cleared", frame_err, 0);
    pop_chk(8'h3C);
    chk("fe_empty", rx_valid, 0);

    // flow control and overrun
    e = cyc + 1 + 2 * 10 * N + LAT;
    fork
      for (int j = 1; j <= 5; j++) begin b = 8'(j); send(b, 1'b1); end
      begin
        wait_cyc(e - 1); chk("fc_cts_before", uart_cts, 1);
        wait_cyc(e);     chk("fc_cts_after", uart_cts, 0);
        chk("fc_head", rx_data, 8'h01);
      end
    join
    repeat (5) tick;
    chk("fc_overrun", overrun, 1);
    chk("fc_cts_full", uart_cts, 0);
    for (int j = 1; j <= 4; j++) begin b = 8'(j); pop_chk(b); end
    chk("fc_empty", rx_valid, 0);
    chk("fc_cts_back", uart_cts, 1);
    err_clr = 1'b1; tick; err_clr = 1'b0;
    chk("fc_ovr_cleared", overrun, 0);

    // full FIFO with pop on the push cycle of 0x77
    e = cyc + 1 + 4 * 10 * N + LAT;
    fork
      begin
        send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1);
        send(8'h44, 1'b1); send(8'h77, 1'b1);
      end
      begin
        wait_cyc(e - 1); rx_ready = 1'b1;
        wait_cyc(e);     rx_ready = 1'b0;
      end
    join
    repeat (5) tick;
    chk("pp_overrun", overrun, 0);
    pop_chk(8'h22); pop_chk(8'h33); pop_chk(8'h44); pop_chk(8'h77);
    chk("pp_empty", rx_valid, 0);

    // reset during data bit 4 with the line held low through release
    repeat (20) tick;
    b = 8'h0D;
    uart_rx = 1'b0; repeat (N) tick;
    for (int i = 0; i < 4; i++) begin uart_rx = b[i]; repeat (N) tick; end
    uart_rx = 1'b0; repeat (4) tick;
    rst = 1'b1; repeat (4) tick;
    chk("mr_cts_rst", uart_cts, 0);
    chk("mr_valid_rst", rx_valid, 0);
    rst = 1'b0; tick;
    chk("mr_cts_rel", uart_cts, 1);
    repeat (150) tick;
    chk("mr_no_start", rx_valid, 0);
    chk("mr_no_ferr", frame_err, 0);
    uart_rx = 1'b1; repeat (20) tick;
    send(8'h0D, 1'b1); repeat (5) tick;
    pop_chk(8'h0D);
    chk("mr_empty", rx_valid, 0);
    repeat (5) tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
